// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : Initiator side of the ALU operand/control interface. Accepts one
//            decoded RV32 instruction per valid/ready transfer, drives
//            registered operands and ALU control to the ALU, samples the ALU's
//            registered result one cycle later and returns result, branch
//            decision and branch target through a valid/ready response port.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction request
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [6:0]            req_opcode,
    input  logic [2:0]            req_funct3,
    input  logic                  req_funct7b5,
    input  logic [DATA_WIDTH-1:0] req_rs1,
    input  logic [DATA_WIDTH-1:0] req_rs2,
    input  logic [DATA_WIDTH-1:0] req_imm,
    input  logic [DATA_WIDTH-1:0] req_pc,
    // ALU interface
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [1:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    // response
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_taken,
    output logic [DATA_WIDTH-1:0] rsp_target,
    output logic                  rsp_illegal
);

    // ALU operation encoding shared with the ALU
    localparam logic [1:0] c_ALU_AND = 2'd0;
    localparam logic [1:0] c_ALU_OR  = 2'd1;
    localparam logic [1:0] c_ALU_ADD = 2'd2;
    localparam logic [1:0] c_ALU_SUB = 2'd3;

    // Controller states
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_CAPT = 2'd2;
    localparam logic [1:0] c_ST_RESP = 2'd3;

    // RV32 opcodes handled here
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_target;
    logic                  r_is_branch;
    logic                  r_is_bne;

    logic                  w_legal;
    logic [1:0]            w_ctrl;
    logic                  w_use_imm;
    logic                  w_branch;
    logic                  w_bne;
    logic [DATA_WIDTH-1:0] w_operand_b;
    logic [DATA_WIDTH-1:0] w_target;

    // Requests are only taken while idle; response and ALU phases block intake
    assign req_ready   = (r_state == c_ST_IDLE);
    assign w_operand_b = w_use_imm ? req_imm : req_rs2;
    assign w_target    = req_pc + req_imm;

    // Decode opcode/funct fields into an ALU operation and operand selection
    always_comb begin
        w_legal   = 1'b0;
        w_ctrl    = c_ALU_ADD;
        w_use_imm = 1'b0;
        w_branch  = 1'b0;
        w_bne     = 1'b0;
        case (req_opcode)
            c_OP_R: begin
                case (req_funct3)
                    3'b000: begin
                        w_legal = 1'b1;
                        w_ctrl  = req_funct7b5 ? c_ALU_SUB : c_ALU_ADD;
                    end
                    3'b111: begin
                        w_legal = 1'b1;
                        w_ctrl  = c_ALU_AND;
                    end
                    3'b110: begin
                        w_legal = 1'b1;
                        w_ctrl  = c_ALU_OR;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            c_OP_I: begin
                // funct7 bit 5 carries immediate bits here and is ignored
                w_use_imm = 1'b1;
                case (req_funct3)
                    3'b000: begin
                        w_legal = 1'b1;
                        w_ctrl  = c_ALU_ADD;
                    end
                    3'b111: begin
                        w_legal = 1'b1;
                        w_ctrl  = c_ALU_AND;
                    end
                    3'b110: begin
                        w_legal = 1'b1;
                        w_ctrl  = c_ALU_OR;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            c_OP_LOAD, c_OP_STORE: begin
                // address generation: rs1 + offset
                w_legal   = 1'b1;
                w_ctrl    = c_ALU_ADD;
                w_use_imm = 1'b1;
            end
            c_OP_BRANCH: begin
                // compare by subtraction; the ALU zero flag gives equality
                w_ctrl   = c_ALU_SUB;
                w_branch = 1'b1;
                case (req_funct3)
                    3'b000:  w_legal = 1'b1;
                    3'b001: begin
                        w_legal = 1'b1;
                        w_bne   = 1'b1;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Issue/capture/respond sequencer with registered ALU and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_target    <= '0;
            r_is_branch <= 1'b0;
            r_is_bne    <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= c_ALU_ADD;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_taken   <= 1'b0;
            rsp_target  <= '0;
            rsp_illegal <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        if (w_legal) begin
                            alu_a       <= req_rs1;
                            alu_b       <= w_operand_b;
                            alu_ctrl    <= w_ctrl;
                            r_target    <= w_target;
                            r_is_branch <= w_branch;
                            r_is_bne    <= w_bne;
                            rsp_illegal <= 1'b0;
                            r_state     <= c_ST_EXEC;
                        end else begin
                            // illegal encodings bypass the ALU entirely
                            rsp_illegal <= 1'b1;
                            rsp_result  <= '0;
                            rsp_taken   <= 1'b0;
                            rsp_target  <= '0;
                            rsp_valid   <= 1'b1;
                            r_state     <= c_ST_RESP;
                        end
                    end
                end
                c_ST_EXEC: begin
                    // ALU registers the operands at the end of this cycle
                    r_state <= c_ST_CAPT;
                end
                c_ST_CAPT: begin
                    rsp_result <= alu_result;
                    if (r_is_branch) begin
                        rsp_taken  <= r_is_bne ? ~alu_zero : alu_zero;
                        rsp_target <= r_target;
                    end else begin
                        rsp_taken  <= 1'b0;
                        rsp_target <= '0;
                    end
                    rsp_valid <= 1'b1;
                    r_state   <= c_ST_RESP;
                end
                c_ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
